// File: rtl/qtree_int_serializer_pkg.sv
// Shared types for the QTree_Int serializer: node word layout, tag values,
// the QNode constructor and the child-pointer extract helper.
package qtree_int_serializer_pkg;

   localparam int ADDR_W_P = 16;
   localparam int DATA_W_P = 67;

   typedef logic [DATA_W_P-1:0] QTree_Int_t;
   typedef logic [ADDR_W_P:0]   Pointer_QTree_Int_t;

   localparam logic [1:0] QNONE  = 2'd0;
   localparam logic [1:0] QVAL   = 2'd1;
   localparam logic [1:0] QNODE  = 2'd2;
   localparam logic [1:0] QERROR = 2'd3;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_FETCH,
      ST_WAIT,
      ST_EMIT,
      ST_POP,
      ST_ABORT
   } ser_state_t;

   // QNode layout: {c3, c2, c1, c0, tag, valid}, c0 starting at bit 3.
   function automatic QTree_Int_t QNode_Int_dc(input logic [ADDR_W_P-1:0] c0,
                                               input logic [ADDR_W_P-1:0] c1,
                                               input logic [ADDR_W_P-1:0] c2,
                                               input logic [ADDR_W_P-1:0] c3);
      return {c3, c2, c1, c0, QNODE, 1'b1};
   endfunction

   function automatic logic [ADDR_W_P-1:0] qnode_child(input QTree_Int_t w,
                                                       input logic [1:0] idx);
      logic [ADDR_W_P-1:0] c;
      case (idx)
         2'd0:    c = w[3+0*ADDR_W_P +: ADDR_W_P];
         2'd1:    c = w[3+1*ADDR_W_P +: ADDR_W_P];
         2'd2:    c = w[3+2*ADDR_W_P +: ADDR_W_P];
         default: c = w[3+3*ADDR_W_P +: ADDR_W_P];
      endcase
      return c;
   endfunction

endpackage

// File: rtl/qtree_int_serializer_frame_stack.sv
// Traversal stack of {node word, next-child index} frames with a
// decrement-in-place on the top frame's index.
module qtree_frame_stack #(
   parameter int DATA_W = 67,
   parameter int DEPTH  = 64,
   localparam int SP_W  = $clog2(DEPTH + 1),
   localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              i_clear,
   input  logic              i_push,
   input  logic [DATA_W-1:0] i_push_word,
   input  logic [1:0]        i_push_idx,
   input  logic              i_pop,
   input  logic              i_dec_idx,
   output logic [DATA_W-1:0] o_top_word,
   output logic [1:0]        o_top_idx,
   output logic [SP_W-1:0]   o_sp,
   output logic              o_full,
   output logic              o_empty
);

   logic [DATA_W-1:0] r_word [DEPTH];
   logic [1:0]        r_idx  [DEPTH];
   logic [SP_W-1:0]   r_sp;
   logic [PTR_W-1:0]  w_top_ptr;
   logic [PTR_W-1:0]  w_push_ptr;
   logic              w_full;
   logic              w_empty;

   assign w_full     = (r_sp == SP_W'(DEPTH));
   assign w_empty    = (r_sp == '0);
   assign w_top_ptr  = PTR_W'(r_sp - 1'b1);
   assign w_push_ptr = PTR_W'(r_sp);

   always_ff @(posedge clk) begin
      if (i_push && !w_full) begin
         r_word[w_push_ptr] <= i_push_word;
         r_idx[w_push_ptr]  <= i_push_idx;
      end else if (i_dec_idx && !w_empty) begin
         r_idx[w_top_ptr] <= r_idx[w_top_ptr] - 2'd1;
      end
   end

   always_ff @(posedge clk) begin
      if (reset || i_clear)
         r_sp <= '0;
      else if (i_push && !w_full)
         r_sp <= r_sp + 1'b1;
      else if (i_pop && !w_empty)
         r_sp <= r_sp - 1'b1;
   end

   // An empty stack has no meaningful top; present zeros instead of a stale frame.
   assign o_top_word = w_empty ? '0 : r_word[w_top_ptr];
   assign o_top_idx  = w_empty ? 2'd0 : r_idx[w_top_ptr];
   assign o_sp       = r_sp;
   assign o_full     = w_full;
   assign o_empty    = w_empty;

endmodule

// File: rtl/qtree_int_serializer.sv
// Walks a heap-resident QTree_Int from a root pointer and streams every node
// as one AXI-stream beat in postfix order (c3, c2, c1, c0, node), tlast on root.
//
// state | meaning
// IDLE  | ready for a root pointer
// FETCH | heap read request held until accepted
// WAIT  | awaiting the read response (one request outstanding)
// EMIT  | beat on the stream, held until tready
// POP   | advance to next child of top frame, or emit the finished node
// ABORT | stack overflow; drop the traversal
module qtree_int_serializer
   import qtree_int_serializer_pkg::*;
#(
   parameter int ADDR_W = ADDR_W_P,
   parameter int DATA_W = DATA_W_P,
   parameter int DEPTH  = 64
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [ADDR_W:0]   root_d,
   output logic              root_r,
   output logic [ADDR_W:0]   rd_addr_d,
   input  logic              rd_addr_r,
   input  logic [DATA_W-1:0] rd_data_d,
   output logic              rd_data_r,
   output logic [DATA_W-2:0] o_QTree_Int_tdata,
   output logic              o_QTree_Int_tvalid,
   input  logic              o_QTree_Int_tready,
   output logic              o_QTree_Int_tlast,
   output logic              busy,
   output logic              overflow
);

   localparam int SP_W = $clog2(DEPTH + 1);

   ser_state_t        r_state;
   ser_state_t        w_next;
   logic [ADDR_W-1:0] r_addr;
   logic [DATA_W-2:0] r_beat;
   logic              r_last;
   logic              r_overflow;

   logic [ADDR_W-1:0] w_addr_nxt;
   logic              w_load_addr;
   logic [DATA_W-2:0] w_beat_nxt;
   logic              w_last_nxt;
   logic              w_load_beat;
   logic              w_set_ovf;
   logic              w_push;
   logic              w_pop;
   logic              w_dec;
   logic              w_clear;

   logic [DATA_W-1:0] w_top_word;
   logic [1:0]        w_top_idx;
   logic [SP_W-1:0]   w_sp;
   logic              w_full;
   logic              w_empty;

   qtree_frame_stack #(
      .DATA_W (DATA_W),
      .DEPTH  (DEPTH)
   ) u_stack (
      .clk         (clk),
      .reset       (reset),
      .i_clear     (w_clear),
      .i_push      (w_push),
      .i_push_word (rd_data_d),
      .i_push_idx  (2'd3),
      .i_pop       (w_pop),
      .i_dec_idx   (w_dec),
      .o_top_word  (w_top_word),
      .o_top_idx   (w_top_idx),
      .o_sp        (w_sp),
      .o_full      (w_full),
      .o_empty     (w_empty)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state    <= ST_IDLE;
         r_addr     <= '0;
         r_beat     <= '0;
         r_last     <= 1'b0;
         r_overflow <= 1'b0;
      end else begin
         r_state <= w_next;
         if (w_load_addr)
            r_addr <= w_addr_nxt;
         if (w_load_beat) begin
            r_beat <= w_beat_nxt;
            r_last <= w_last_nxt;
         end
         if (w_set_ovf)
            r_overflow <= 1'b1;
      end
   end

   always_comb begin
      w_next      = r_state;
      w_addr_nxt  = r_addr;
      w_load_addr = 1'b0;
      w_beat_nxt  = r_beat;
      w_last_nxt  = r_last;
      w_load_beat = 1'b0;
      w_set_ovf   = 1'b0;
      w_push      = 1'b0;
      w_pop       = 1'b0;
      w_dec       = 1'b0;
      w_clear     = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (root_d[0]) begin
               w_addr_nxt  = root_d[ADDR_W:1];
               w_load_addr = 1'b1;
               w_next      = ST_FETCH;
            end
         end
         ST_FETCH: begin
            if (rd_addr_r)
               w_next = ST_WAIT;
         end
         ST_WAIT: begin
            if (rd_data_d[0]) begin
               if (rd_data_d[2:1] != QNODE) begin
                  w_beat_nxt  = rd_data_d[DATA_W-1:1];
                  w_last_nxt  = w_empty;
                  w_load_beat = 1'b1;
                  w_next      = ST_EMIT;
               end else if (w_full) begin
                  w_set_ovf = 1'b1;
                  w_next    = ST_ABORT;
               end else begin
                  w_push      = 1'b1;
                  w_addr_nxt  = qnode_child(rd_data_d, 2'd3);
                  w_load_addr = 1'b1;
                  w_next      = ST_FETCH;
               end
            end
         end
         ST_EMIT: begin
            if (o_QTree_Int_tready)
               w_next = w_empty ? ST_IDLE : ST_POP;
         end
         ST_POP: begin
            if (w_top_idx != 2'd0) begin
               w_dec       = 1'b1;
               w_addr_nxt  = qnode_child(w_top_word, w_top_idx - 2'd1);
               w_load_addr = 1'b1;
               w_next      = ST_FETCH;
            end else begin
               // The loader rebuilds child pointers, so the node beat carries only its tag.
               w_pop       = 1'b1;
               w_beat_nxt  = {{(DATA_W-3){1'b0}}, QNODE};
               w_last_nxt  = (w_sp == SP_W'(1));
               w_load_beat = 1'b1;
               w_next      = ST_EMIT;
            end
         end
         ST_ABORT: begin
            w_clear = 1'b1;
            w_next  = ST_IDLE;
         end
         default: w_next = ST_IDLE;
      endcase
   end

   assign root_r             = (r_state == ST_IDLE);
   assign rd_addr_d          = (r_state == ST_FETCH) ? {r_addr, 1'b1} : '0;
   assign rd_data_r          = (r_state == ST_WAIT);
   assign o_QTree_Int_tdata  = r_beat;
   assign o_QTree_Int_tvalid = (r_state == ST_EMIT);
   assign o_QTree_Int_tlast  = (r_state == ST_EMIT) && r_last;
   assign busy               = (r_state != ST_IDLE) && (r_state != ST_ABORT);
   assign overflow           = r_overflow;

endmodule

// File: doc/qtree_int_serializer.md
Name: qtree_int_serializer

Overview:
- Transmit-side counterpart of the QTree_Int stream loader.
- Takes a root Pointer_QTree_Int_t and walks the heap tree through a single read port.
- Emits every node as one AXI-stream beat in postfix order, with tlast on the root beat.
- Sits between the dataflow result pointer and the host-side AXI-stream sink, so a tree built on-chip can be read back with the same beat format the loader consumes.

Parameters:
- ADDR_W, 16, heap pointer width (Pointer_QTree_Int_t payload, excluding valid bit)
- DATA_W, 67, QTree_Int_t width including valid bit [0]
- DEPTH, 64, traversal stack depth (maximum tree height)

Ports:
- clk  in  1  clock
- reset  in  1  synchronous active-high reset
- root_d  in  ADDR_W+1  root pointer; [0]=valid, [ADDR_W:1]=address
- root_r  out  1  root accepted when root_d[0]&&root_r
- rd_addr_d  out  ADDR_W+1  heap read request; [0]=valid
- rd_addr_r  in  1  heap accepts request
- rd_data_d  in  DATA_W  heap read response; [0]=valid
- rd_data_r  out  1  serializer accepts response
- o_QTree_Int_tdata  out  DATA_W-1  node beat = QTree_Int_t[DATA_W-1:1]
- o_QTree_Int_tvalid  out  1  AXI-stream valid
- o_QTree_Int_tready  in  1  AXI-stream ready
- o_QTree_Int_tlast  out  1  high on root beat only
- busy  out  1  traversal in progress
- overflow  out  1  sticky; stack depth exceeded

Behaviour:
- Reset: root_r=1, rd_addr_d=0, rd_data_r=0, tvalid=0, tlast=0, tdata=0, busy=0, overflow=0, stack pointer=0. Reset mid-traversal discards all state; no further beats are emitted.
- Tag decode on bits [2:1]:
  - 0, 1, 3 are leaves; the beat is the fetched word[DATA_W-1:1] unchanged.
  - 2 = QNode with four child pointers c0..c3.
- Order: QNode(c0,c1,c2,c3) emits subtree c3, c2, c1, c0, then the node beat. The node beat's child pointer fields are forced to 0, since the loader rebuilds them.
- FSM states:
  - IDLE: root_r=1. On root accept, latch address, busy=1 → FETCH.
  - FETCH: drive rd_addr_d valid with the current address until rd_addr_r → WAIT. At most one request is outstanding.
  - WAIT: rd_data_r=1. When rd_data_d[0]:
    - leaf → EMIT.
    - QNode: if sp==DEPTH, set overflow=1 → ABORT. Otherwise push {word, idx=3} and set address=child[3] → FETCH.
  - EMIT: tvalid=1, holding tdata and tlast stable until tready. The root beat is the one emitted with sp==0. After handshake: sp==0 → IDLE (busy=0); else → POP.
  - POP: examine top frame.
    - idx>0: decrement idx, address=child[idx-1] → FETCH.
    - idx==0: pop the frame, load the node beat → EMIT.
  - ABORT: busy=0, no tlast; return to IDLE next cycle. overflow stays set until reset.
- Latency: root accept → rd_addr valid on the next cycle. Response → tvalid on the next cycle for a leaf.
- tvalid must not drop without a handshake, and tdata must not change while tvalid&&!tready.
- A root_d presented while busy is not accepted (root_r=0).
- rd_data_d arriving outside WAIT is ignored (rd_data_r=0).
- Stack uses a frame register array. sp is ceil(log2(DEPTH+1)) bits with no wrap; overflow is checked before push.

Decomposition:
- Already in mMaskKron_package: QTree_Int_t, Pointer_QTree_Int_t and the QNode_Int_dc constructor.
- Add to that package: tag constants QNONE/QVAL/QNODE/QERROR and a QNode child-field extract function.
- One sub-module: qtree_frame_stack (push/pop/top, DEPTH frames of {DATA_W word, 2-bit idx}, full/empty flags).

Test Plan:
- Single leaf QVal 5 at address 0x10; root_d=0x10 valid → exactly one beat, tdata tag=1, payload=5, tlast=1; busy returns to 0.
- QNode at 0x20 with children 0x21..0x24, leaves with values 1..4 → 5 beats in order: 4, 3, 2, 1, then the node beat; tlast only on beat 5; node beat child fields are 0.
- Two-level tree, inner QNode as c3 → 9 beats with correct postfix order. Random tready deassertion holds tdata stable and loses no beats.
- Heap with random 0-5 cycle rd_addr_r/rd_data_d delays → same beat sequence as the zero-wait run; never more than one outstanding request.
- DEPTH=2, chain of 3 nested QNodes → overflow=1, busy=0, no tlast beat; a new root_d accepted afterwards still sets tlast correctly.
- Assert reset during EMIT with tvalid=1 → next cycle tvalid=0, root_r=1, sp=0; a fresh root traverses correctly.
